uart_tx_fifo_param: RTL and testbench

//  Parametrised UART transmitter with a small TX FIFO and a valid/ready input handshake.

---
 rtl/uart_tx_fifo_param.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_param.sv
// rtl/uart_tx_fifo_param.sv - parametrised UART transmitter with TX FIFO and valid/ready input
// Words pushed on i_valid && o_ready are queued and framed as
// start / DATA_BITS LSB-first / optional parity / STOP_BITS stop,
// each bit CLK_DIV clocks long, frames sent back-to-back while words remain.
module uart_tx_fifo_param #(
  parameter int CLK_DIV    = 2604,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_valid,
  input  logic [DATA_BITS-1:0]          i_data,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_PRE   = CW'(CLK_DIV - 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_fifo_param: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo_param: PARITY must be 0, 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo_param: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               r_state;
  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_not_empty;
  logic                 w_bit_end;
  logic                 w_frame_end;
  logic [DATA_BITS-1:0] w_head;

  assign w_push       = i_valid && o_ready;
  assign w_not_empty  = (r_level != '0);
  assign w_bit_end    = (r_cnt == CNT_LAST);
  assign w_frame_end  = (r_state == S_STOP) && w_bit_end && (r_idx == STOP_LAST);
  // A word leaves the FIFO either from IDLE or straight out of the last stop cycle.
  assign w_pop        = w_not_empty && ((r_state == S_IDLE) || w_frame_end);
  assign w_head       = r_mem[r_rd_ptr];
  assign o_ready      = (r_level != LVL_FULL);
  assign o_fifo_level = r_level;

  // FIFO storage: data only, no reset needed since pointers gate its use
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Frame FSM with registered line, busy and done outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      o_tx      <= 1'b1;
      o_busy    <= 1'b0;
      o_tx_done <= 1'b0;
    end else begin
      // Raised one edge early so the pulse lands on the final stop cycle.
      o_tx_done <= (r_state == S_STOP) && (r_cnt == CNT_PRE) && (r_idx == STOP_LAST);
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
            o_tx    <= 1'b0;
            o_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            o_tx    <= r_shift[0];
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == DATA_LAST) begin
              r_idx <= '0;
              if (PARITY != 0) begin
                o_tx    <= r_par;
                r_state <= S_PAR;
              end else begin
                o_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_shift <= r_shift >> 1;
              o_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PAR: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            o_tx    <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_idx == STOP_LAST) begin
              r_idx <= '0;
              if (w_not_empty) begin
                r_shift <= w_head;
                r_par   <= (PARITY == 1) ? ~^w_head : ^w_head;
                o_tx    <= 1'b0;
                r_state <= S_START;
              end else begin
                o_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          o_tx    <= 1'b1;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb/tb_uart_tx_fifo_param.sv - randomized self-checking bench for uart_tx_fifo_param
module tb_uart_tx_fifo_param;

  localparam int CDIV  = 4;
  localparam int DEPTH = 4;
  localparam int DB [4] = '{8, 8, 8, 7};
  localparam int PAR[4] = '{0, 2, 1, 0};
  localparam int SB [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] r_valid = '0;
  logic [7:0] r_data = '0;
  logic [3:0] w_rdy, w_tx, w_busy, w_done;
  logic [2:0] w_lvl [4];

  uart_tx_fifo_param #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_d0 (
    .i_clk(clk), .i_rst(rst), .i_valid(r_valid[0]), .i_data(r_data),
    .o_ready(w_rdy[0]), .o_tx(w_tx[0]), .o_busy(w_busy[0]), .o_tx_done(w_done[0]), .o_fifo_level(w_lvl[0]));
  uart_tx_fifo_param #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_d1 (
    .i_clk(clk), .i_rst(rst), .i_valid(r_valid[1]), .i_data(r_data),
    .o_ready(w_rdy[1]), .o_tx(w_tx[1]), .o_busy(w_busy[1]), .o_tx_done(w_done[1]), .o_fifo_level(w_lvl[1]));
  uart_tx_fifo_param #(.CLK_DIV(CDIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_d2 (
    .i_clk(clk), .i_rst(rst), .i_valid(r_valid[2]), .i_data(r_data),
    .o_ready(w_rdy[2]), .o_tx(w_tx[2]), .o_busy(w_busy[2]), .o_tx_done(w_done[2]), .o_fifo_level(w_lvl[2]));
  uart_tx_fifo_param #(.CLK_DIV(CDIV), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_d3 (
    .i_clk(clk), .i_rst(rst), .i_valid(r_valid[3]), .i_data(r_data[6:0]),
    .o_ready(w_rdy[3]), .o_tx(w_tx[3]), .o_busy(w_busy[3]), .o_tx_done(w_done[3]), .o_fifo_level(w_lvl[3]));

  // free-running clock
  always #5 clk = ~clk;

  int         vectors = 0;
  int         fails   = 0;
  int         act     = 0;
  int         e       = 0;
  int         m_start = -1;
  int         m_free  = 0;
  logic [7:0] m_word  = '0;
  logic [7:0] m_q [$];
  bit         m_acc;
  logic [6:0] s_vec, x_vec;

  function automatic int flen(input int d);
    return CDIV * (1 + DB[d] + ((PAR[d] != 0) ? 1 : 0) + SB[d]);
  endfunction

  // Level of frame bit b (0 = start) for word w on DUT d.
  function automatic logic exp_bit(input int d, input logic [7:0] w, input int b);
    int ones;
    ones = 0;
    if (b == 0) return 1'b0;
    if (b <= DB[d]) return w[b-1];
    if (PAR[d] != 0 && b == DB[d] + 1) begin
      for (int i = 0; i < DB[d]; i++) ones += int'(w[i]);
      if (PAR[d] == 1) return (ones % 2) == 0;
      return (ones % 2) == 1;
    end
    return 1'b1;
  endfunction

  task automatic select_dut(input int d);
    act = d;
    m_q.delete();
    m_start = -1;
    m_free  = 0;
  endtask

  // One clock: update the queue/timing model, then sample DUT and model.
  task automatic tick();
    bit   push;
    int   len, pos;
    logic xt, xb, xd;
    push = r_valid[act] && (m_q.size() != DEPTH);
    @(posedge clk);
    e++;
    m_acc = 1'b0;
    len = flen(act);
    if (rst) begin
      m_q.delete();
      m_start = -1;
      m_free  = 0;
    end else begin
      if (e >= m_free && m_q.size() > 0) begin
        m_word  = m_q.pop_front();
        m_start = e;
        m_free  = e + len;
      end
      if (push) begin
        m_q.push_back(r_data);
        m_acc = 1'b1;
      end
    end
    #1;
    if (m_start >= 0 && (e - m_start) < len) begin
      pos = e - m_start;
      xt = exp_bit(act, m_word, pos / CDIV);
      xb = 1'b1;
      xd = (pos == len - 1);
    end else begin
      xt = 1'b1; xb = 1'b0; xd = 1'b0;
    end
    x_vec = {xt, xb, xd, (m_q.size() != DEPTH), 3'(m_q.size())};
    s_vec = {w_tx[act], w_busy[act], w_done[act], w_rdy[act], w_lvl[act]};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r_valid = '0;
    tick();
    tick();
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if ({w_tx[d], w_busy[d], w_done[d], w_rdy[d], w_lvl[d]} !== 7'b1001000) begin
        fails++;
        $display("FAIL reset d%0d: got %b want %b", d,
                 {w_tx[d], w_busy[d], w_done[d], w_rdy[d], w_lvl[d]}, 7'b1001000);
      end
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single(input int d, input logic [7:0] w);
    int n_done;
    n_done = 0;
    select_dut(d);
    r_data = w;
    r_valid[d] = 1'b1;
    for (int i = 0; i < flen(d) + 3; i++) begin
      tick();
      r_valid[d] = 1'b0;
      n_done += int'(s_vec[4]);
      vectors++;
      if (s_vec !== x_vec) begin
        fails++;
        $display("FAIL single d%0d w=%h cyc%0d: got %b want %b", d, w, i, s_vec, x_vec);
      end
    end
    vectors++;
    if (n_done !== 1) begin
      fails++;
      $display("FAIL single_done_count d%0d: got %0d want 1", d, n_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wl [5];
    int idx, n_done;
    wl[0] = 8'h11; wl[1] = 8'h22; wl[2] = 8'h33; wl[3] = 8'h44; wl[4] = 8'h55;
    idx = 0;
    n_done = 0;
    select_dut(0);
    r_data = wl[0];
    r_valid[0] = 1'b1;
    for (int i = 0; i < 5 * flen(0) + 6; i++) begin
      tick();
      if (m_acc) idx++;
      if (idx < 5) r_data = wl[idx];
      else r_valid[0] = 1'b0;
      n_done += int'(s_vec[4]);
      vectors++;
      if (s_vec !== x_vec) begin
        fails++;
        $display("FAIL back_to_back cyc%0d: got %b want %b", i, s_vec, x_vec);
      end
    end
    vectors++;
    if (n_done !== 5 || idx !== 5) begin
      fails++;
      $display("FAIL back_to_back_counts: done %0d accepted %0d want 5 and 5", n_done, idx);
    end
  endtask

  task automatic test_random_stream();
    select_dut(0);
    for (int i = 0; i < 300 + 6 * flen(0); i++) begin
      r_valid[0] = (i < 300) && ($urandom_range(0, 3) != 0);
      r_data = 8'($urandom_range(0, 255));
      tick();
      vectors++;
      if (s_vec !== x_vec) begin
        fails++;
        $display("FAIL random_stream cyc%0d: got %b want %b", i, s_vec, x_vec);
      end
    end
    r_valid[0] = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int n_done;
    n_done = 0;
    select_dut(0);
    r_valid[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 3) r_data = 8'($urandom_range(0, 255));
      else r_valid[0] = 1'b0;
      tick();
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({w_tx[0], w_busy[0], w_done[0], w_rdy[0], w_lvl[0]} !== 7'b1001000) begin
      fails++;
      $display("FAIL reset_mid_frame_async: got %b want %b",
               {w_tx[0], w_busy[0], w_done[0], w_rdy[0], w_lvl[0]}, 7'b1001000);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (s_vec !== x_vec) begin
        fails++;
        $display("FAIL reset_mid_frame_hold cyc%0d: got %b want %b", i, s_vec, x_vec);
      end
    end
    rst = 1'b0;
    r_data = 8'($urandom_range(0, 255));
    r_valid[0] = 1'b1;
    for (int i = 0; i < flen(0) + 3; i++) begin
      tick();
      r_valid[0] = 1'b0;
      n_done += int'(s_vec[4]);
      vectors++;
      if (s_vec !== x_vec) begin
        fails++;
        $display("FAIL reset_mid_frame_after cyc%0d: got %b want %b", i, s_vec, x_vec);
      end
    end
    vectors++;
    if (n_done !== 1) begin
      fails++;
      $display("FAIL reset_mid_frame_done_count: got %0d want 1", n_done);
    end
  endtask

  task automatic test_push_on_stop_edge();
    bit found;
    int n_done;
    found = 1'b0;
    n_done = 0;
    select_dut(0);
    r_data = 8'($urandom_range(0, 255));
    r_valid[0] = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      r_valid[0] = 1'b0;
      n_done += int'(s_vec[4]);
      vectors++;
      if (s_vec !== x_vec) begin
        fails++;
        $display("FAIL stop_edge_first cyc%0d: got %b want %b", i, s_vec, x_vec);
      end
      found = (m_start >= 0) && (e - m_start == flen(0) - 1);
    end
    vectors++;
    if (!found) begin
      fails++;
      $display("FAIL stop_edge_reach: last stop cycle not reached, got 0 want 1");
    end
    r_data = 8'($urandom_range(0, 255));
    r_valid[0] = 1'b1;
    tick();
    r_valid[0] = 1'b0;
    vectors++;
    if ({w_tx[0], w_busy[0], w_lvl[0]} !== 5'b10001) begin
      fails++;
      $display("FAIL stop_edge_gap: got %b want %b", {w_tx[0], w_busy[0], w_lvl[0]}, 5'b10001);
    end
    for (int i = 0; i < flen(0) + 3; i++) begin
      tick();
      n_done += int'(s_vec[4]);
      vectors++;
      if (s_vec !== x_vec) begin
        fails++;
        $display("FAIL stop_edge_second cyc%0d: got %b want %b", i, s_vec, x_vec);
      end
    end
    vectors++;
    if (n_done !== 2) begin
      fails++;
      $display("FAIL stop_edge_done_count: got %0d want 2", n_done);
    end
  endtask

  initial begin
    test_reset();
    test_single(0, 8'hA5);
    test_single(1, 8'h07);
    test_single(2, 8'h07);
    test_single(3, 8'h55);
    for (int d = 0; d < 4; d++) begin
      test_single(d, 8'($urandom_range(0, 255)));
      test_single(d, 8'($urandom_range(0, 255)));
    end
    test_back_to_back();
    test_random_stream();
    test_reset_mid_frame();
    test_push_on_stop_edge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
